sdram_arb2: RTL and testbench

//  Two-requester round-robin arbiter in front of sdram_cnt's single-command

---
 rtl/sdram_arb2.sv | 216 +++++++++++++++++++++
 tb/tb_sdram_arb2.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb2.sv
// ----------------------------------------------------------------------------
// sdram_arb2
//   Two-requester round-robin arbiter in front of the single-command user port
//   of sdram_cnt. One transaction is outstanding at a time. A grant latches the
//   winner's command into sd_* and pulses sd_en for one cycle. The arbiter then
//   follows sdram_cnt's rdy/valid handshake until the command completes and
//   acks the granted requester. A 16-bit watchdog ends a transaction that
//   never completes. It acks with err=1 and leaves the read data untouched.
//
// Ports
//   tb_clk, tb_rst         clock, asynchronous active-high reset
//   rN_req/we/addr/wdata   requester N command (N=0,1); held until rN_ack
//   rN_ack                 one-cycle completion pulse
//   rN_rdata               read data, updated only on a successful read ack
//   rN_err                 qualifies rN_ack: watchdog expired
//   sd_en/we/addr/wdata    command to sdram_cnt (en is a one-cycle pulse)
//   sd_rdy/valid/rdata     status and read data from sdram_cnt
// ----------------------------------------------------------------------------
module sdram_arb2 #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int TIMEOUT = 10000
) (
    input  logic          tb_clk,
    input  logic          tb_rst,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_err,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_err,

    output logic          sd_en,
    output logic          sd_we,
    output logic [AW-1:0] sd_addr,
    output logic [DW-1:0] sd_wdata,
    input  logic          sd_rdy,
    input  logic          sd_valid,
    input  logic [DW-1:0] sd_rdata
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACC  = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // The expiry decision is taken one cycle early so that the registered ack
    // appears exactly TIMEOUT cycles after the sd_en cycle.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]    state_r;
    logic          last_r;      // port granted most recently (1 = r1)
    logic          gnt_r;       // port owning the outstanding transaction
    logic [15:0]   wd_r;        // watchdog, cycles spent in WAIT_*

    logic          req0_s;
    logic          req1_s;
    logic          pick_s;
    logic          grant_s;
    logic          g_we_s;
    logic [AW-1:0] g_addr_s;
    logic [DW-1:0] g_wdata_s;

    logic          done_s;
    logic          to_done_s;
    logic          expire_s;
    logic          fin_s;

    // Arbitration: mask a port during its own ack cycle, because its req is
    // still high then. Alternate on contention.
    always_comb begin
        req0_s = r0_req & ~r0_ack;
        req1_s = r1_req & ~r1_ack;

        if (req0_s && req1_s) begin
            pick_s = ~last_r;
        end else if (req1_s) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end

        grant_s = (state_r == ST_IDLE) && sd_rdy && (req0_s || req1_s);

        if (pick_s) begin
            g_we_s    = r1_we;
            g_addr_s  = r1_addr;
            g_wdata_s = r1_wdata;
        end else begin
            g_we_s    = r0_we;
            g_addr_s  = r0_addr;
            g_wdata_s = r0_wdata;
        end
    end

    // Completion detection. The sd_en cycle itself is ignored. The controller
    // has not seen the command yet, so rdy/valid then still describe the past.
    always_comb begin
        done_s    = 1'b0;
        to_done_s = 1'b0;
        case (state_r)
            ST_WAIT_ACC: begin
                if (sd_en) begin
                    done_s    = 1'b0;
                    to_done_s = 1'b0;
                end else begin
                    done_s    = ~sd_we & sd_valid;
                    to_done_s = ~sd_rdy;
                end
            end
            ST_WAIT_DONE: begin
                if (sd_we) begin
                    done_s = sd_rdy;
                end else begin
                    done_s = sd_valid;
                end
                to_done_s = 1'b0;
            end
            default: begin
                done_s    = 1'b0;
                to_done_s = 1'b0;
            end
        endcase

        // A genuine completion wins over a watchdog expiry in the same cycle.
        expire_s = (state_r != ST_IDLE) && (wd_r == WD_LAST) && !done_s;
        fin_s    = done_s | expire_s;
    end

    // FSM, round-robin pointer, watchdog and the registered command to sdram_cnt.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_r  <= ST_IDLE;
            last_r   <= 1'b1;            // makes r0 win the first contention
            gnt_r    <= 1'b0;
            wd_r     <= 16'd0;
            sd_en    <= 1'b0;
            sd_we    <= 1'b0;
            sd_addr  <= {AW{1'b0}};
            sd_wdata <= {DW{1'b0}};
        end else begin
            sd_en <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wd_r <= 16'd0;
                    if (grant_s) begin
                        state_r  <= ST_WAIT_ACC;
                        gnt_r    <= pick_s;
                        last_r   <= pick_s;
                        sd_en    <= 1'b1;
                        sd_we    <= g_we_s;
                        sd_addr  <= g_addr_s;
                        sd_wdata <= g_wdata_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_ACC, ST_WAIT_DONE: begin
                    if (fin_s) begin
                        state_r <= ST_IDLE;
                        wd_r    <= 16'd0;
                    end else begin
                        wd_r <= wd_r + 16'd1;
                        if (to_done_s) begin
                            state_r <= ST_WAIT_DONE;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wd_r    <= 16'd0;
                end
            endcase
        end
    end

    // Requester-side ack/err pulses and read data capture. Only the granted
    // port responds. Read data moves only on a successful read.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            r0_ack   <= 1'b0;
            r0_err   <= 1'b0;
            r0_rdata <= {DW{1'b0}};
            r1_ack   <= 1'b0;
            r1_err   <= 1'b0;
            r1_rdata <= {DW{1'b0}};
        end else begin
            r0_ack <= fin_s & ~gnt_r;
            r0_err <= expire_s & ~gnt_r;
            r1_ack <= fin_s & gnt_r;
            r1_err <= expire_s & gnt_r;
            if (done_s && !sd_we) begin
                if (gnt_r) begin
                    r1_rdata <= sd_rdata;
                end else begin
                    r0_rdata <= sd_rdata;
                end
            end else begin
                r0_rdata <= r0_rdata;
                r1_rdata <= r1_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arb2.sv
// ----------------------------------------------------------------------------
// tb_sdram_arb2
//   Directed bench for sdram_arb2 with a small behavioural stand-in for
//   sdram_cnt. The stand-in drops rdy for `lat` cycles per command. It can be
//   told to stall forever so that the watchdog path fires.
// ----------------------------------------------------------------------------
module tb_sdram_arb2;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 50;

    logic          tb_clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_ack, r0_err;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_ack, r1_err;
    logic [DW-1:0] r1_rdata;
    logic          sd_en, sd_we;
    logic [AW-1:0] sd_addr;
    logic [DW-1:0] sd_wdata;
    logic          sd_rdy, sd_valid;
    logic [DW-1:0] sd_rdata;

    sdram_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .tb_clk(tb_clk), .tb_rst(tb_rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .sd_en(sd_en), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
        .sd_rdy(sd_rdy), .sd_valid(sd_valid), .sd_rdata(sd_rdata)
    );

    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    int n_ack0 = 0;
    int n_ack1 = 0;
    always @(negedge tb_clk) begin
        if (r0_ack) n_ack0 <= n_ack0 + 1;
        if (r1_ack) n_ack1 <= n_ack1 + 1;
    end

    // ---------------- controller stand-in ----------------
    logic          stall = 1'b0;
    int            lat = 3;
    int            en_cyc = 0;
    logic          s_busy;
    int            s_cnt;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    logic [DW-1:0] mem [0:4095];

    always @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            s_busy   <= 1'b0;
            s_cnt    <= 0;
            sd_rdy   <= 1'b1;
            sd_valid <= 1'b0;
            sd_rdata <= '0;
        end else begin
            sd_valid <= 1'b0;
            if (!s_busy) begin
                sd_rdy <= 1'b1;
                if (sd_en) begin
                    s_busy <= 1'b1;
                    sd_rdy <= 1'b0;
                    s_cnt  <= lat;
                    s_we   <= sd_we;
                    s_addr <= sd_addr;
                    s_wd   <= sd_wdata;
                    en_cyc <= cyc;
                end
            end else if (s_cnt != 0) begin
                s_cnt <= s_cnt - 1;
            end else if (!stall) begin
                s_busy <= 1'b0;
                sd_rdy <= 1'b1;
                if (s_we) mem[s_addr] <= s_wd;
                else begin
                    sd_valid <= 1'b1;
                    sd_rdata <= mem[s_addr];
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad = 0;
    logic [DW-1:0] last_rd [0:1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge tb_clk);
        #1;
    endtask

    // Raise a request from port p and hold it until its ack, bounded.
    task automatic txn(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                       output logic er, output int ack_cyc, output logic ok);
        int lim;
        ok = 1'b0; rd = '0; er = 1'b0; ack_cyc = 0; lim = 0;
        if (p == 0) begin r0_we = we; r0_addr = a; r0_wdata = wd; r0_req = 1'b1; end
        else        begin r1_we = we; r1_addr = a; r1_wdata = wd; r1_req = 1'b1; end
        while (!ok && lim < 300) begin
            @(posedge tb_clk); #1;
            lim++;
            if (p == 0 && r0_ack) begin ok = 1'b1; rd = r0_rdata; er = r0_err; ack_cyc = cyc; r0_req = 1'b0; end
            if (p == 1 && r1_ack) begin ok = 1'b1; rd = r1_rdata; er = r1_err; ack_cyc = cyc; r1_req = 1'b0; end
        end
        if (!ok) begin
            if (p == 0) r0_req = 1'b0; else r1_req = 1'b0;
        end
    endtask

    // One isolated transaction with full checking; exp_rd is ignored on writes.
    task automatic run_chk(input string nm, input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        int a0, a1, ac;
        logic [DW-1:0] rd;
        logic er, ok;
        @(posedge tb_clk); #1;
        a0 = n_ack0; a1 = n_ack1;
        txn(p, we, a, wd, rd, er, ac, ok);
        settle();
        if (!we) last_rd[p] = exp_rd;
        check({nm, " ack"}, 32'(ok), 32'd1);
        check({nm, " err"}, 32'(er), 32'd0);
        check({nm, " rdata"}, rd, last_rd[p]);
        check({nm, " own acks"}, (p == 0) ? n_ack0 - a0 : n_ack1 - a1, 32'd1);
        check({nm, " other acks"}, (p == 0) ? n_ack1 - a1 : n_ack0 - a0, 32'd0);
    endtask

    task automatic chk_zero(input string nm);
        check({nm, " sd_en"}, 32'(sd_en), 32'd0);
        check({nm, " sd_we"}, 32'(sd_we), 32'd0);
        check({nm, " sd_addr"}, 32'(sd_addr), 32'd0);
        check({nm, " sd_wdata"}, sd_wdata, 32'd0);
        check({nm, " acks"}, {30'd0, r1_ack, r0_ack}, 32'd0);
        check({nm, " errs"}, {30'd0, r1_err, r0_err}, 32'd0);
        check({nm, " r0_rdata"}, r0_rdata, 32'd0);
        check({nm, " r1_rdata"}, r1_rdata, 32'd0);
    endtask

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vt [10];

    logic [DW-1:0] rd0, rd1;
    logic          er0, er1, ok0, ok1;
    int            c0, c1, a0, a1, k, lim;
    int            s_ack [4];
    logic [DW-1:0] s_rd [4];
    logic [DW-1:0] sb [0:31];
    bit            sbv [0:31];

    initial begin
        #1000000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int i = 0; i < 32; i++) sbv[i] = 1'b0;

        vt[0] = '{0, 1'b1, 12'h123, 32'hDEADBEEF, 32'h0};
        vt[1] = '{0, 1'b0, 12'h123, 32'h0,        32'hDEADBEEF};
        vt[2] = '{1, 1'b1, 12'h7FF, 32'hA5A5A5A5, 32'h0};
        vt[3] = '{1, 1'b0, 12'h7FF, 32'h0,        32'hA5A5A5A5};
        vt[4] = '{0, 1'b1, 12'h000, 32'h00000000, 32'h0};
        vt[5] = '{0, 1'b0, 12'h000, 32'h0,        32'h00000000};
        vt[6] = '{1, 1'b1, 12'hFFF, 32'hFFFFFFFF, 32'h0};
        vt[7] = '{1, 1'b0, 12'hFFF, 32'h0,        32'hFFFFFFFF};
        vt[8] = '{0, 1'b0, 12'h020, 32'h0,        32'h22222222};
        vt[9] = '{1, 1'b0, 12'h030, 32'h0,        32'h33333333};

        // Reset state
        repeat (3) @(posedge tb_clk);
        #1;
        chk_zero("in reset");
        tb_rst = 1'b0;
        settle();
        chk_zero("after reset");

        // Simultaneous writes right after reset: r0 is favoured
        @(posedge tb_clk); #1;
        fork
            txn(0, 1'b1, 12'h010, 32'h11111111, rd0, er0, c0, ok0);
            txn(1, 1'b1, 12'h020, 32'h22222222, rd1, er1, c1, ok1);
        join
        settle();
        check("tie1 both acked", {30'd0, ok1, ok0}, 32'd3);
        check("tie1 r0 first", 32'(c0 < c1), 32'd1);

        // Read back in order r1, r0 so that r0 was granted last
        run_chk("rb r1 0x020", 1, 1'b0, 12'h020, 32'h0, 32'h22222222);
        run_chk("rb r0 0x010", 0, 1'b0, 12'h010, 32'h0, 32'h11111111);

        // Repeat contention: r1 now goes first
        @(posedge tb_clk); #1;
        fork
            txn(0, 1'b1, 12'h030, 32'h33333333, rd0, er0, c0, ok0);
            txn(1, 1'b1, 12'h040, 32'h44444444, rd1, er1, c1, ok1);
        join
        settle();
        check("tie2 both acked", {30'd0, ok1, ok0}, 32'd3);
        check("tie2 r1 first", 32'(c1 < c0), 32'd1);

        // Table of isolated transactions
        for (int i = 0; i < 10; i++) begin
            run_chk($sformatf("vec%0d", i), vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
        end

        // r0 held for 4 reads, r1 one write: r1 must slip in after r0's first
        @(posedge tb_clk); #1;
        fork
            begin
                r0_we = 1'b0; r0_addr = 12'h123; r0_req = 1'b1;
                k = 0; lim = 0;
                while (k < 4 && lim < 400) begin
                    @(posedge tb_clk); #1;
                    lim++;
                    if (r0_ack) begin s_ack[k] = cyc; s_rd[k] = r0_rdata; k++; end
                end
                r0_req = 1'b0;
            end
            txn(1, 1'b1, 12'h055, 32'h55555555, rd1, er1, c1, ok1);
        join
        settle();
        last_rd[0] = 32'hDEADBEEF;
        check("starve r0 ack count", k, 32'd4);
        check("starve r1 acked", 32'(ok1), 32'd1);
        check("starve r1 between", 32'(k == 4 && c1 > s_ack[0] && c1 < s_ack[1]), 32'd1);
        for (int i = 0; i < 4; i++) check($sformatf("starve rd%0d", i), s_rd[i], 32'hDEADBEEF);
        run_chk("starve rb 0x055", 1, 1'b0, 12'h055, 32'h0, 32'h55555555);

        // Watchdog: controller never returns rdy
        stall = 1'b1;
        @(posedge tb_clk); #1;
        txn(0, 1'b0, 12'h010, 32'h0, rd0, er0, c0, ok0);
        settle();
        check("wd ack", 32'(ok0), 32'd1);
        check("wd err", 32'(er0), 32'd1);
        check("wd latency", c0 - en_cyc, 32'(TO));
        check("wd rdata kept", rd0, last_rd[0]);
        stall = 1'b0;
        run_chk("post wd read", 0, 1'b0, 12'h010, 32'h0, 32'h11111111);

        // Reset while waiting for completion of a slow write
        lat = 20;
        @(posedge tb_clk); #1;
        r1_we = 1'b1; r1_addr = 12'h0AA; r1_wdata = 32'hCAFEF00D; r1_req = 1'b1;
        k = 0; lim = 0;
        while (k < 3 && lim < 100) begin
            @(posedge tb_clk); #1;
            lim++;
            if (!sd_rdy) k++; else k = 0;
        end
        check("rst reached wait", k, 32'd3);
        #2 tb_rst = 1'b1;
        #1;
        chk_zero("mid reset");
        r1_req = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1 tb_rst = 1'b0;
        lat = 3;
        last_rd[0] = '0;
        last_rd[1] = '0;
        a0 = n_ack0; a1 = n_ack1;
        repeat (30) @(posedge tb_clk);
        settle();
        check("rst no ack", (n_ack0 - a0) + (n_ack1 - a1), 32'd0);
        run_chk("rst fresh wr", 1, 1'b1, 12'hFFE, 32'h0F0F0F0F, 32'h0);
        run_chk("rst fresh rd", 1, 1'b0, 12'hFFE, 32'h0, 32'h0F0F0F0F);

        // Mixed traffic from both ports against a scoreboard
        for (int it = 0; it < 128; it++) begin
            int i0, i1;
            logic w0, w1;
            logic [DW-1:0] d0, d1;
            i0 = 2 * int'($urandom_range(0, 15));
            i1 = i0 + 1 + 2 * int'($urandom_range(0, 14)) - 2 * (i0 / 2);
            i1 = 2 * int'($urandom_range(0, 15)) + 1;
            w0 = !sbv[i0] || ($urandom_range(0, 1) == 1);
            w1 = !sbv[i1] || ($urandom_range(0, 1) == 1);
            d0 = $urandom;
            d1 = $urandom;
            @(posedge tb_clk); #1;
            fork
                txn(0, w0, 12'h200 + 12'(i0), d0, rd0, er0, c0, ok0);
                txn(1, w1, 12'h200 + 12'(i1), d1, rd1, er1, c1, ok1);
            join
            settle();
            check($sformatf("rnd%0d ok", it), {28'd0, er1, er0, ok1, ok0}, 32'd3);
            if (w0) begin sb[i0] = d0; sbv[i0] = 1'b1; end
            else check($sformatf("rnd%0d r0 data", it), rd0, sb[i0]);
            if (w1) begin sb[i1] = d1; sbv[i1] = 1'b1; end
            else check($sformatf("rnd%0d r1 data", it), rd1, sb[i1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
